// File: rtl/fifo_rd_stream_adapter.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream_adapter
//   Reader end of a FIFO read interface (rd / empty / rdata) in the rclk domain.
//   Issues rd strobes and captures the read data one cycle later into a
//   2-entry skid buffer. The buffered words are presented as a valid/ready
//   stream. It sustains one word per cycle across the FIFO's 1-cycle read
//   latency and never drops data.
//
// Parameters
//   DATAWIDTH   width of FIFO read data and stream data
//
// Ports
//   rclk        in   read-domain clock
//   rrst        in   synchronous active-high reset
//   fifo_empty  in   FIFO empty flag (rclk domain)
//   fifo_rd     out  read strobe, one word per high cycle
//   fifo_rdata  in   FIFO read data, valid the cycle after fifo_rd
//   m_valid     out  stream word available
//   m_ready     in   downstream accepts the word
//   m_data      out  stream data
//   xfer_cnt    out  (RD_STATS_EN) pops, wrapping 16-bit counter
//   stall_cnt   out  (RD_STATS_EN) m_valid & !m_ready cycles, saturating
//
// Build option: define RD_STATS_EN to add the xfer_cnt / stall_cnt ports.
// -----------------------------------------------------------------------------
module fifo_rd_stream_adapter #(
    parameter int DATAWIDTH = 8
) (
    input  logic                 rclk,
    input  logic                 rrst,
    input  logic                 fifo_empty,
    output logic                 fifo_rd,
    input  logic [DATAWIDTH-1:0] fifo_rdata,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATAWIDTH-1:0] m_data
`ifdef RD_STATS_EN
    ,
    output logic [15:0]          xfer_cnt,
    output logic [15:0]          stall_cnt
`endif
);

    logic [1:0][DATAWIDTH-1:0] store;
    logic [1:0]                count;
    logic                      inflight;
    logic                      head;
    logic                      tail;
    logic                      push;
    logic                      pop;
    logic [1:0]                committed;

    assign m_valid = (count != 2'd0);
    assign m_data  = store[head];
    assign pop     = m_valid & m_ready;
    assign push    = inflight;

    // Credits: a slot must be free for every word already requested. A pop
    // in the current cycle frees a slot in time for the read issued now,
    // because that read's data only lands at the end of the next cycle.
    assign committed = count + {1'b0, inflight};
    assign fifo_rd   = !fifo_empty & !rrst & ((committed < 2'd2) | pop);

    always_ff @(posedge rclk) begin
        if (rrst) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            store    <= '0;
        end else begin
            inflight <= fifo_rd;
            count    <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                store[tail] <= fifo_rdata;
                tail        <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
        end
    end

`ifdef RD_STATS_EN
    always_ff @(posedge rclk) begin
        if (rrst) begin
            xfer_cnt  <= 16'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (pop) begin
                xfer_cnt <= xfer_cnt + 16'd1;
            end
            if (m_valid && !m_ready && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
